cp0_exc_unit: RTL and testbench
===============================

CP0_EXC_UNIT -- requirements
Module: cp0_exc_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as the codebase does: clk and rst_n.
REQ-002 The block SHALL have these parameters, one per line as name, default, meaning:
- PRID_VALUE, 32'h4255_4141, value returned by PRId.
- EXC_ENTRY, 32'h0000_4180, handler address driven on ExcEntry.
REQ-003 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- ExcCode_M  in  5  M-stage exception code, produced by the upstream exception-code muxes; `No_ExcCode` = none.
- PC_M  in  32  M-stage instruction PC.
- BD_M  in  1  M-stage instruction sits in a branch delay slot.
- HWInt  in  6  external interrupt lines, level.
- CP0WE  in  1  mtc0 write strobe.
- CP0Addr  in  5  register number for read and write.
- CP0WD  in  32  write data.
- EXLClr  in  1  eret in M.
- CP0RD  out  32  read data.
- EPCOut  out  32  eret target.
- ExcEntry  out  32  constant EXC_ENTRY.
- Req  out  1  take exception or interrupt this cycle, flush pipeline.

Function
REQ-004 The block SHALL implement the following registers; unlisted bits read 0 and ignore writes; unlisted addresses read 0:
- SR(12): IM[15:10], EXL[1], IE[0].
- Cause(13): BD[31], IP[15:10], ExcCode[6:2]; not software-writable.
- EPC(14): 32 bits, read/write.
- PRId(15): read-only.
- Count(9), Compare(11): 32 bits, read/write.
REQ-005 CP0RD SHALL be combinational from CP0Addr and the current register values, with no write-through.
REQ-006 The block SHALL form the effective pending vector IPe = HWInt | {TimerPend, 5'b0}.
REQ-007 The block SHALL compute IntReq = |(IPe & SR.IM) & SR.IE & !SR.EXL.
REQ-008 The block SHALL compute ExcReq = (ExcCode_M != `No_ExcCode`) & !SR.EXL.
REQ-009 Req SHALL equal IntReq | ExcReq, combinationally, in the same cycle.
REQ-010 When IntReq and ExcReq are both asserted, the interrupt SHALL have priority.
REQ-011 On a clock edge with Req=1, the block SHALL update:
- SR.EXL <= 1.
- Cause.BD <= BD_M.
- Cause.ExcCode <= IntReq ? 5'd0 : ExcCode_M.
- EPC <= BD_M ? PC_M-4 : PC_M, 32-bit wrap.
REQ-012 On a Req edge, a CP0WE or EXLClr asserted in the same cycle SHALL be ignored.
REQ-013 Cause.IP SHALL be loaded with IPe on every clock edge, independent of Req.
REQ-014 With Req=0, EXLClr=1 SHALL clear SR.EXL at the next edge.
REQ-015 With Req=0, CP0WE=1 SHALL write the addressed writable register at the next edge.
REQ-016 If EXLClr and CP0WE targeting SR coincide, the write SHALL be applied first and EXL then cleared.
REQ-017 EPCOut SHALL equal CP0WD when CP0WE=1, CP0Addr=14 and Req=0; otherwise it SHALL equal EPC.
REQ-018 Count SHALL increment by 1 every cycle, wrapping 32'hFFFF_FFFF -> 0.
REQ-019 A CP0WE write to Count SHALL replace the increment in that cycle.
REQ-020 TimerPend SHALL set on the edge where the next Count value equals Compare.
REQ-021 A write to Compare SHALL clear TimerPend and take priority over a same-edge set.
REQ-022 TimerPend SHALL be otherwise sticky.
REQ-023 Exception latency SHALL be 0 cycles: Req is raised in the same cycle and the state update occurs at the following edge.
REQ-024 While SR.EXL=1, nested exceptions and interrupts SHALL be suppressed and EPC held.

Reset
REQ-025 While rst_n=0, the following SHALL hold:
- SR, Cause, EPC, Count, Compare and TimerPend are 0.
- PRId reads PRID_VALUE.
- Req is forced 0.
REQ-026 Reset SHALL take effect asynchronously and discard any exception in progress.
REQ-027 The first edge after rst_n rises SHALL behave as a normal cycle.

Verification
REQ-028 Overflow: ExcCode_M=12, PC_M=32'h3010, BD_M=0, EXL=0 -> Req=1 that cycle; after the edge, EPC=32'h3010, Cause[6:2]=12, SR.EXL=1.
REQ-029 Delay-slot AdES: ExcCode_M=5, PC_M=32'h3024, BD_M=1 -> EPC=32'h3020, Cause.BD=1.
REQ-030 Interrupt priority: SR=32'h0000_0401 via mtc0, HWInt=6'b000001 and ExcCode_M=10 in the same cycle -> Req=1; after the edge, Cause[6:2]=0 and Cause[10]=1.
REQ-031 Nesting and eret: with EXL=1, ExcCode_M=4 -> Req=0 and EPC unchanged; EXLClr=1 -> EXL=0 next cycle; mtc0 EPC=32'h4000 with EXLClr in the same cycle -> EPCOut=32'h4000 that cycle.
REQ-032 Timer: Compare=20 with Count written 0, SR.IM[15]=1 and SR.IE=1 -> TimerPend and Req assert when Count reaches 20; writing Compare -> Req drops the following cycle.
REQ-033 Reset mid-exception: rst_n pulled low while Req=1 -> Req=0 and SR=Cause=EPC=0 immediately, with no clock edge.

Source files
------------

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: MIPS-style CP0 register file with exception/interrupt request logic.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ExcCode_M         M-stage exception code (`No_ExcCode` = none)
//   PC_M, BD_M        M-stage PC and branch-delay-slot flag
//   HWInt             level-sensitive external interrupt lines
//   CP0WE/CP0Addr/CP0WD  mtc0 write strobe, register number, write data
//   EXLClr            eret in M
//   CP0RD             combinational read data for CP0Addr
//   EPCOut            eret target, forwarding a same-cycle mtc0 to EPC
//   ExcEntry          handler address
//   Req               take exception/interrupt this cycle
`ifndef No_ExcCode
`define No_ExcCode 5'd0
`endif

module cp0_exc_unit #(
    parameter logic [31:0] PRID_VALUE = 32'h4255_4141,
    parameter logic [31:0] EXC_ENTRY  = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ExcCode_M,
    input  logic [31:0] PC_M,
    input  logic        BD_M,
    input  logic [5:0]  HWInt,
    input  logic        CP0WE,
    input  logic [4:0]  CP0Addr,
    input  logic [31:0] CP0WD,
    input  logic        EXLClr,
    output logic [31:0] CP0RD,
    output logic [31:0] EPCOut,
    output logic [31:0] ExcEntry,
    output logic        Req
);
    logic [5:0]  sr_im_q, sr_im_d;
    logic        sr_exl_q, sr_exl_d;
    logic        sr_ie_q, sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q, cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_pend_q, timer_pend_d;
    logic [5:0]  ipe;
    logic        int_req, exc_req, wr, wr_sr, wr_epc, wr_count, wr_compare;

    assign ExcEntry = EXC_ENTRY;

    always_comb begin
        ipe        = HWInt | {timer_pend_q, 5'b0};
        int_req    = (|(ipe & sr_im_q)) & sr_ie_q & ~sr_exl_q;
        exc_req    = (ExcCode_M != `No_ExcCode) & ~sr_exl_q;
        // Req is held low during reset even if an exception code is presented
        Req        = rst_n & (int_req | exc_req);
        // a taken exception swallows any same-cycle mtc0
        wr         = CP0WE & ~Req;
        wr_sr      = wr & (CP0Addr == 5'd12);
        wr_epc     = wr & (CP0Addr == 5'd14);
        wr_count   = wr & (CP0Addr == 5'd9);
        wr_compare = wr & (CP0Addr == 5'd11);
        sr_im_d    = wr_sr ? CP0WD[15:10] : sr_im_q;
        sr_ie_d    = wr_sr ? CP0WD[0] : sr_ie_q;
        // eret clears EXL after any same-cycle SR write has been applied
        sr_exl_d   = Req ? 1'b1 : EXLClr ? 1'b0 : wr_sr ? CP0WD[1] : sr_exl_q;
        cause_bd_d  = Req ? BD_M : cause_bd_q;
        cause_exc_d = Req ? (int_req ? 5'd0 : ExcCode_M) : cause_exc_q;
        cause_ip_d  = ipe;
        epc_d       = Req ? PC_M - (BD_M ? 32'd4 : 32'd0) : wr_epc ? CP0WD : epc_q;
        count_d     = wr_count ? CP0WD : count_q + 32'd1;
        compare_d   = wr_compare ? CP0WD : compare_q;
        timer_pend_d = wr_compare ? 1'b0 : (count_d == compare_q) ? 1'b1 : timer_pend_q;
        EPCOut      = wr_epc ? CP0WD : epc_q;
        CP0RD = (CP0Addr == 5'd9)  ? count_q :
                (CP0Addr == 5'd11) ? compare_q :
                (CP0Addr == 5'd12) ? {16'b0, sr_im_q, 8'b0, sr_exl_q, sr_ie_q} :
                (CP0Addr == 5'd13) ? {cause_bd_q, 15'b0, cause_ip_q, 3'b0, cause_exc_q, 2'b0} :
                (CP0Addr == 5'd14) ? epc_q :
                (CP0Addr == 5'd15) ? PRID_VALUE : 32'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_im_q      <= '0;
            sr_exl_q     <= 1'b0;
            sr_ie_q      <= 1'b0;
            cause_bd_q   <= 1'b0;
            cause_ip_q   <= '0;
            cause_exc_q  <= '0;
            epc_q        <= '0;
            count_q      <= '0;
            compare_q    <= '0;
            timer_pend_q <= 1'b0;
        end else begin
            sr_im_q      <= sr_im_d;
            sr_exl_q     <= sr_exl_d;
            sr_ie_q      <= sr_ie_d;
            cause_bd_q   <= cause_bd_d;
            cause_ip_q   <= cause_ip_d;
            cause_exc_q  <= cause_exc_d;
            epc_q        <= epc_d;
            count_q      <= count_d;
            compare_q    <= compare_d;
            timer_pend_q <= timer_pend_d;
        end
    end
endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb_cp0_exc_unit: scoreboard bench for cp0_exc_unit against an architectural register-array model.
module tb_cp0_exc_unit;
    localparam logic [31:0] PRID   = 32'h4255_4141;
    localparam logic [31:0] ENTRY  = 32'h0000_4180;
    localparam logic [4:0]  NO_EXC = 5'd0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  ExcCode_M = '0;
    logic [31:0] PC_M = '0;
    logic        BD_M = 1'b0;
    logic [5:0]  HWInt = '0;
    logic        CP0WE = 1'b0;
    logic [4:0]  CP0Addr = '0;
    logic [31:0] CP0WD = '0;
    logic        EXLClr = 1'b0;
    logic [31:0] CP0RD, EPCOut, ExcEntry;
    logic        Req;

    cp0_exc_unit dut (
        .clk(clk), .rst_n(rst_n), .ExcCode_M(ExcCode_M), .PC_M(PC_M), .BD_M(BD_M),
        .HWInt(HWInt), .CP0WE(CP0WE), .CP0Addr(CP0Addr), .CP0WD(CP0WD), .EXLClr(EXLClr),
        .CP0RD(CP0RD), .EPCOut(EPCOut), .ExcEntry(ExcEntry), .Req(Req)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic [31:0] rd;
        logic [31:0] epcout;
        logic [31:0] entry;
        logic [4:0]  addr;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] mreg [0:31];
    logic        m_tp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] m_ipe();
        return HWInt | (m_tp ? 6'b100000 : 6'b000000);
    endfunction

    function automatic logic m_int();
        return (|(m_ipe() & mreg[12][15:10])) && mreg[12][0] && !mreg[12][1];
    endfunction

    function automatic logic m_exc();
        return (ExcCode_M != NO_EXC) && !mreg[12][1];
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        return (a == 5'd15) ? PRID : mreg[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        m_tp = 1'b0;
    endtask

    task automatic model_step();
        logic        it, req, cmp_wr;
        logic [5:0]  ipe;
        logic [31:0] cnt_next, old_cmp;
        it       = m_int();
        req      = it || m_exc();
        ipe      = m_ipe();
        old_cmp  = mreg[11];
        cnt_next = mreg[9] + 32'd1;
        cmp_wr   = 1'b0;
        if (req) begin
            mreg[12][1]   = 1'b1;
            mreg[13][31]  = BD_M;
            mreg[13][6:2] = it ? 5'd0 : ExcCode_M;
            mreg[14]      = BD_M ? PC_M - 32'd4 : PC_M;
        end else begin
            if (CP0WE) begin
                case (CP0Addr)
                    5'd9:  cnt_next = CP0WD;
                    5'd11: begin mreg[11] = CP0WD; cmp_wr = 1'b1; end
                    5'd12: mreg[12] = CP0WD & 32'h0000_FC03;
                    5'd14: mreg[14] = CP0WD;
                    default: ;
                endcase
            end
            if (EXLClr) mreg[12][1] = 1'b0;
        end
        m_tp = cmp_wr ? 1'b0 : (cnt_next == old_cmp) ? 1'b1 : m_tp;
        mreg[9] = cnt_next;
        mreg[13][15:10] = ipe;
    endtask

    task automatic push_exp();
        exp_t e;
        e.req    = m_int() || m_exc();
        e.rd     = m_rd(CP0Addr);
        e.epcout = (CP0WE && CP0Addr == 5'd14 && !e.req) ? CP0WD : mreg[14];
        e.entry  = ENTRY;
        e.addr   = CP0Addr;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic drive(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                         input logic [5:0] hw, input logic we, input logic [4:0] addr,
                         input logic [31:0] wd, input logic clr);
        ExcCode_M = code; PC_M = pc; BD_M = bd; HWInt = hw;
        CP0WE = we; CP0Addr = addr; CP0WD = wd; EXLClr = clr;
        push_exp();
        tick();
    endtask

    task automatic idle(input logic [4:0] addr);
        drive(NO_EXC, 32'h0, 1'b0, 6'b0, 1'b0, addr, 32'h0, 1'b0);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] wd, input logic clr);
        drive(NO_EXC, 32'h0, 1'b0, 6'b0, 1'b1, addr, wd, clr);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("Req", {31'b0, Req}, {31'b0, e.req});
                chk($sformatf("CP0RD[%0d]", e.addr), CP0RD, e.rd);
                chk("EPCOut", EPCOut, e.epcout);
                chk("ExcEntry", ExcEntry, e.entry);
            end
        end
    end

    initial begin
        logic [4:0] at [0:7];
        at[0] = 5'd9; at[1] = 5'd11; at[2] = 5'd12; at[3] = 5'd13;
        at[4] = 5'd14; at[5] = 5'd15; at[6] = 5'd0; at[7] = 5'd31;
        m_reset();
        ExcCode_M = 5'd12;
        #5;
        chk("reset_req", {31'b0, Req}, 32'd0);
        CP0Addr = 5'd15; #1;
        chk("reset_prid", CP0RD, PRID);
        CP0Addr = 5'd12; #1;
        chk("reset_sr", CP0RD, 32'd0);
        CP0Addr = 5'd9; #1;
        chk("reset_count", CP0RD, 32'd0);
        ExcCode_M = NO_EXC;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // overflow
        idle(12);
        drive(5'd12, 32'h3010, 1'b0, 6'b0, 1'b0, 5'd14, 32'h0, 1'b0);
        idle(14); idle(13); idle(12);
        mtc0(5'd0, 32'h0, 1'b1);
        idle(12);
        // delay-slot AdES
        drive(5'd5, 32'h3024, 1'b1, 6'b0, 1'b0, 5'd14, 32'h0, 1'b0);
        idle(14); idle(13);
        drive(NO_EXC, 32'h0, 1'b0, 6'b0, 1'b0, 5'd12, 32'h0, 1'b1);
        // interrupt over exception
        mtc0(5'd12, 32'h0000_0401, 1'b0);
        drive(5'd10, 32'h3100, 1'b0, 6'b000001, 1'b0, 5'd13, 32'h0, 1'b0);
        idle(13); idle(12);
        // nesting suppressed, eret, mtc0 EPC forwarding
        drive(5'd4, 32'h3200, 1'b0, 6'b0, 1'b0, 5'd14, 32'h0, 1'b0);
        idle(14);
        drive(NO_EXC, 32'h0, 1'b0, 6'b0, 1'b0, 5'd12, 32'h0, 1'b1);
        idle(12);
        drive(5'd8, 32'h3300, 1'b0, 6'b0, 1'b0, 5'd12, 32'h0, 1'b0);
        drive(NO_EXC, 32'h0, 1'b0, 6'b0, 1'b1, 5'd14, 32'h4000, 1'b1);
        idle(14); idle(12);
        // timer
        mtc0(5'd12, 32'h0000_8001, 1'b0);
        mtc0(5'd11, 32'd20, 1'b0);
        mtc0(5'd9, 32'd0, 1'b0);
        repeat (24) idle(9);
        mtc0(5'd11, 32'd1000, 1'b1);
        idle(12); idle(13);
        // wrap of Count
        mtc0(5'd9, 32'hFFFF_FFFE, 1'b0);
        repeat (3) idle(9);
        // reset mid-exception
        mtc0(5'd12, 32'h0, 1'b1);
        ExcCode_M = 5'd12; PC_M = 32'h3400; BD_M = 1'b0; HWInt = 6'b0;
        CP0WE = 1'b0; CP0Addr = 5'd14; EXLClr = 1'b0;
        push_exp();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_req", {31'b0, Req}, 32'd0);
        CP0Addr = 5'd12; #1;
        chk("rst_sr", CP0RD, 32'd0);
        CP0Addr = 5'd13; #1;
        chk("rst_cause", CP0RD, 32'd0);
        CP0Addr = 5'd14; #1;
        chk("rst_epc", CP0RD, 32'd0);
        m_reset();
        #1;
        rst_n = 1'b1;
        tick();
        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [4:0]  code, addr;
            logic [31:0] wd;
            logic        we;
            code = ($urandom % 10 < 7) ? NO_EXC : 5'($urandom_range(1, 31));
            addr = at[$urandom % 8];
            we   = ($urandom % 4 == 0);
            wd   = $urandom;
            if (we && addr == 5'd9 && $urandom % 2 == 0) wd = mreg[11] - 32'($urandom_range(0, 5));
            drive(code, $urandom, 1'($urandom % 2), ($urandom % 8 == 0) ? 6'($urandom) : 6'b0,
                  we, addr, wd, ($urandom % 6 == 0));
        end
        @(negedge clk);
        #1;
        chk("drain", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
